stoch_scaled_avg_mat: RTL and testbench

//  NUM_ROWS x NUM_COLS matrix of stochastic scaled-sum units with a valid strobe.
//  - Each element sums NUM_POPS input bitstreams and divides by DIVISOR.
//  - When DIVISOR == NUM_POPS the element is a plain stochastic average.
//  - Keeps a residue counter, a 2-stage pipeline, a sync clear and per-element

---
 rtl/stoch_scaled_avg_mat.sv | 100 ++++++++++
 tb/tb_stoch_scaled_avg_mat.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stoch_scaled_avg_mat.sv
// stoch_scaled_avg_mat: matrix of stochastic scaled-sum units (popcount / DIVISOR) with a residue.
// Each element adds the popcount of its NUM_POPS input bitstreams to a residue and emits a 1
// whenever the running sum reaches DIVISOR, so the output density is min(1, density_sum/DIVISOR).
// Ports:
//   CLK      rising-edge clock
//   nRST     synchronous active-low reset (overrides clr and en)
//   en       A carries a valid sample this cycle
//   clr      synchronous clear: residues and SAT back to init, in-flight samples dropped
//   A        [NUM_ROWS][NUM_COLS][NUM_POPS] input bitstreams
//   Y        [NUM_ROWS][NUM_COLS] output bitstreams, two cycles after the sample
//   y_valid  Y holds a valid sample
//   SAT      [NUM_ROWS][NUM_COLS] sticky residue-saturation flags
// Optional feature macro: STOCH_SCALED_AVG_MAT_ROUND_EN starts the residue at floor(DIVISOR/2)
// so the output tracks the rounded rather than truncated quotient.
module stoch_scaled_avg_mat #(
    parameter int NUM_POPS = 2,
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3,
    parameter int DIVISOR  = NUM_POPS,
    parameter int RES_W    = $clog2(NUM_POPS + DIVISOR) + 1
) (
    input  logic                                             CLK,
    input  logic                                             nRST,
    input  logic                                             en,
    input  logic                                             clr,
    input  logic [NUM_ROWS-1:0][NUM_COLS-1:0][NUM_POPS-1:0]  A,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]                Y,
    output logic                                             y_valid,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]                SAT
);
    localparam int POP_W = $clog2(NUM_POPS + 1);
    // one bit wider than either operand so residue + popcount cannot wrap
    localparam int SUM_W = (RES_W > POP_W ? RES_W : POP_W) + 1;
`ifdef STOCH_SCALED_AVG_MAT_ROUND_EN
    localparam int RES_INIT = DIVISOR / 2;
`else
    localparam int RES_INIT = 0;
`endif
    localparam logic [SUM_W-1:0] DIV_S   = SUM_W'(DIVISOR);
    localparam logic [SUM_W-1:0] RES_MAX = SUM_W'((1 << RES_W) - 1);

    logic v1_q, y_valid_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            v1_q      <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            v1_q      <= en & ~clr;
            y_valid_q <= v1_q & ~clr;
        end
    end

    assign y_valid = y_valid_q;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            logic [POP_W-1:0] pop_d, pop_q;
            logic [RES_W-1:0] res_d, res_q;
            logic [SUM_W-1:0] sum, rem;
            logic             y_d, y_q, ovf, sat_q;

            always_comb begin
                pop_d = '0;
                for (int k = 0; k < NUM_POPS; k++) pop_d = pop_d + POP_W'(A[r][c][k]);
                sum   = SUM_W'(res_q) + SUM_W'(pop_q);
                y_d   = sum >= DIV_S;
                rem   = y_d ? sum - DIV_S : sum;
                ovf   = rem > RES_MAX;
                res_d = ovf ? '1 : rem[RES_W-1:0];
            end

            // pop_q may load during clr; v1_q is low next cycle so that sample is never consumed
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    pop_q <= '0;
                    res_q <= RES_W'(RES_INIT);
                    sat_q <= 1'b0;
                    y_q   <= 1'b0;
                end else begin
                    if (en) pop_q <= pop_d;
                    if (clr) begin
                        res_q <= RES_W'(RES_INIT);
                        sat_q <= 1'b0;
                        y_q   <= 1'b0;
                    end else if (v1_q) begin
                        res_q <= res_d;
                        sat_q <= sat_q | ovf;
                        y_q   <= y_d;
                    end else begin
                        y_q   <= 1'b0;
                    end
                end
            end

            assign Y[r][c]   = y_q;
            assign SAT[r][c] = sat_q;
        end
    end
endmodule

// File: tb/tb_stoch_scaled_avg_mat.sv
// tb_stoch_scaled_avg_mat: random and directed checks of two configurations against an arithmetic model.
module tb_stoch_scaled_avg_mat;
    localparam int NP  = 2;
    localparam int NR  = 3, NC  = 3, D  = 2, RW  = $clog2(NP + D) + 1;
    localparam int NR2 = 2, NC2 = 2, D2 = 1, RW2 = 2;
    localparam int N1  = NR * NC, NE = N1 + NR2 * NC2;
    localparam int AW  = NR * NC * NP, AW2 = NR2 * NC2 * NP;
`ifdef STOCH_SCALED_AVG_MAT_ROUND_EN
    localparam int INIT1 = D / 2, INIT2 = D2 / 2;
`else
    localparam int INIT1 = 0, INIT2 = 0;
`endif

    logic clk = 1'b0, nrst, en, clr;
    logic [NR-1:0][NC-1:0][NP-1:0]   a;
    logic [NR2-1:0][NC2-1:0][NP-1:0] a2;
    logic [NR-1:0][NC-1:0]           y, sat;
    logic [NR2-1:0][NC2-1:0]         y2, sat2;
    logic                            yv, yv2;

    int n_checks = 0, n_errors = 0;

    int mres[NE], mpop[NE];
    bit my[NE], msat[NE];
    bit mv1[2], myv[2];

    always #5 clk = ~clk;

    stoch_scaled_avg_mat #(.NUM_POPS(NP), .NUM_ROWS(NR), .NUM_COLS(NC), .DIVISOR(D)) dut (
        .CLK(clk), .nRST(nrst), .en(en), .clr(clr), .A(a), .Y(y), .y_valid(yv), .SAT(sat)
    );

    stoch_scaled_avg_mat #(.NUM_POPS(NP), .NUM_ROWS(NR2), .NUM_COLS(NC2), .DIVISOR(D2), .RES_W(RW2)) dut2 (
        .CLK(clk), .nRST(nrst), .en(en), .clr(clr), .A(a2), .Y(y2), .y_valid(yv2), .SAT(sat2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input logic [NP-1:0] b);
        int n = 0;
        for (int k = 0; k < NP; k++) n += int'(b[k]);
        return n;
    endfunction

    function automatic logic [NP-1:0] bits_of(input int e);
        if (e < N1) return a[e / NC][e % NC];
        return a2[(e - N1) / NC2][(e - N1) % NC2];
    endfunction

    // one clock of the reference: output stage consumes the previous sample, then the new one is latched
    task automatic step(input bit n, input bit e_, input bit c_);
        logic [N1-1:0]    ey1, es1;
        logic [NE-N1-1:0] ey2, es2;
        nrst = n;
        en   = e_;
        clr  = c_;
        @(posedge clk);
        for (int e = 0; e < NE; e++) begin
            int i    = e < N1 ? 0 : 1;
            int dv   = i == 0 ? D : D2;
            int mx   = i == 0 ? (1 << RW) - 1 : (1 << RW2) - 1;
            int init = i == 0 ? INIT1 : INIT2;
            int s;
            if (!n) begin
                mres[e] = init; msat[e] = 0; my[e] = 0; mpop[e] = 0;
            end else begin
                if (c_) begin
                    mres[e] = init; msat[e] = 0; my[e] = 0;
                end else if (mv1[i]) begin
                    s     = mres[e] + mpop[e];
                    my[e] = s >= dv;
                    if (my[e]) s -= dv;
                    if (s > mx) begin
                        mres[e] = mx; msat[e] = 1;
                    end else mres[e] = s;
                end else my[e] = 0;
                if (e_) mpop[e] = ones(bits_of(e));
            end
        end
        for (int i = 0; i < 2; i++) begin
            myv[i] = n && !c_ && mv1[i];
            mv1[i] = n && e_ && !c_;
        end
        #1;
        for (int e = 0; e < NE; e++) begin
            if (e < N1) begin ey1[e] = my[e]; es1[e] = msat[e]; end
            else begin ey2[e-N1] = my[e]; es2[e-N1] = msat[e]; end
        end
        check("y_valid", 32'(yv), 32'(myv[0]));
        check("Y", 32'(y), 32'(ey1));
        check("SAT", 32'(sat), 32'(es1));
        check("y_valid2", 32'(yv2), 32'(myv[1]));
        check("Y2", 32'(y2), 32'(ey2));
        check("SAT2", 32'(sat2), 32'(es2));
    endtask

    initial begin
        nrst = 1'b0; en = 1'b0; clr = 1'b0; a = '0; a2 = '0;
        step(0, 0, 0);
        step(0, 1, 0);
        // all-ones into [0][0]; second instance saturates under all-ones
        a[0][0] = 2'b11;
        a2 = '1;
        for (int k = 0; k < 8; k++) step(1, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0);
        // half density alternates 0/1 from a fresh residue
        step(1, 0, 1);
        a[0][0] = 2'b01;
        for (int k = 0; k < 8; k++) step(1, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        // en gaps hold the residue
        step(1, 0, 1);
        step(1, 1, 0); step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
        step(1, 0, 0); step(1, 0, 0);
        // clr pulse in continuous traffic
        for (int k = 0; k < 4; k++) step(1, 1, 0);
        step(1, 1, 1);
        for (int k = 0; k < 5; k++) step(1, 1, 0);
        // reset mid-stream overrides en and clr
        step(0, 1, 1);
        for (int k = 0; k < 6; k++) step(1, 1, 0);
        for (int k = 0; k < 400; k++) begin
            a  = AW'($urandom);
            a2 = AW2'($urandom);
            step($urandom_range(49) != 0, $urandom_range(3) != 0, $urandom_range(19) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
